// File: rtl/sqrt_recon_pkg.sv
// Shared definitions for the square-root cluster: widths, FSM state encoding,
// and iteration counter width.
package sqrt_pkg;
    localparam int DATA_W = 64;
    localparam int ROOT_W = DATA_W / 2;
    localparam int CNT_W  = $clog2(ROOT_W);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;
endpackage

// File: rtl/sqrt_recon_if.sv
// Operand/result handshake bundle between a producer and sqrt_recon.
interface sqrt_recon_if
    import sqrt_pkg::*;
#(
    parameter int DATA_W = sqrt_pkg::DATA_W
);
    localparam int ROOT_W = DATA_W / 2;

    logic              in_valid;
    logic              in_ready;
    logic [ROOT_W-1:0] root;
    logic [ROOT_W:0]   rem;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] data;
    logic              rem_err;

    modport master (
        output in_valid, root, rem, out_ready,
        input  in_ready, out_valid, data, rem_err
    );

    modport slave (
        input  in_valid, root, rem, out_ready,
        output in_ready, out_valid, data, rem_err
    );
endinterface

// File: rtl/sqrt_recon_dp.sv
// Shift-add multiplier datapath: acc starts at rem and accumulates root*root,
// one multiplier bit per step.
module sqrt_recon_dp
    import sqrt_pkg::*;
#(
    parameter int DATA_W = sqrt_pkg::DATA_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     load,
    input  logic                     step,
    input  logic [DATA_W/2-1:0]      root,
    input  logic [DATA_W/2:0]        rem,
    output logic [DATA_W-1:0]        acc
);
    localparam int ROOT_W = DATA_W / 2;

    logic [DATA_W-1:0] mcand;
    logic [ROOT_W-1:0] mplier;
    logic [DATA_W-1:0] acc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand  <= '0;
            mplier <= '0;
            acc_q  <= '0;
        end else if (load) begin
            mcand  <= {{ROOT_W{1'b0}}, root};
            mplier <= root;
            acc_q  <= DATA_W'(rem);
        end else if (step) begin
            // Carry-out is dropped on purpose: non-canonical rem wraps mod 2^DATA_W.
            if (mplier[0]) begin
                acc_q <= acc_q + mcand;
            end
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
        end
    end

    assign acc = acc_q;
endmodule

// File: rtl/sqrt_recon.sv
// Reconstructs data = root*root + rem with a fixed-latency iterative multiplier
// and flags non-canonical remainders (rem > 2*root).
module sqrt_recon
    import sqrt_pkg::*;
#(
    parameter int DATA_W = sqrt_pkg::DATA_W
) (
    input  logic        clk,
    input  logic        rst_n,
    sqrt_recon_if.slave bus
);
    localparam int ROOT_W = DATA_W / 2;
    localparam int CW     = $clog2(ROOT_W);

    state_t            state;
    state_t            state_nxt;
    logic [CW-1:0]     cnt;
    logic              load;
    logic              step;
    logic              last;
    logic              err_q;
    logic [DATA_W-1:0] acc;

    function automatic logic rem_noncanon(input logic [ROOT_W-1:0] r,
                                          input logic [ROOT_W:0]   m);
        return m > {r, 1'b0};
    endfunction

    assign last = (cnt == CW'(ROOT_W - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (bus.in_valid) begin
                    load      = 1'b1;
                    state_nxt = S_CALC;
                end
            end
            S_CALC: begin
                // Always runs ROOT_W iterations, even once mplier is exhausted.
                step = 1'b1;
                if (last) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            err_q <= 1'b0;
        end else if (load) begin
            cnt   <= '0;
            err_q <= rem_noncanon(bus.root, bus.rem);
        end else if (step) begin
            cnt   <= cnt + 1'b1;
        end
    end

    sqrt_recon_dp #(
        .DATA_W (DATA_W)
    ) u_dp (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .step  (step),
        .root  (bus.root),
        .rem   (bus.rem),
        .acc   (acc)
    );

    assign bus.in_ready  = (state == S_IDLE);
    assign bus.out_valid = (state == S_DONE);
    assign bus.data      = acc;
    assign bus.rem_err   = err_q;
endmodule

// File: doc/sqrt_recon.md
# sqrt_recon

Inverse of the integer square-root block. Takes a (root, remainder) pair and reconstructs the radicand `data = root*root + rem` using an iterative radix-2 shift-add multiplier. It also flags remainders that are not canonical, i.e. `rem > 2*root`. It sits downstream of `sqrt` in the arithmetic cluster. It closes the loop for self-checking and feeds any consumer that needs the squared value back at full 64-bit width.

## Interface
- `DATA_W`, default 64: radicand width; must be even.
- `ROOT_W`, default `DATA_W/2`: root width; derived, not overridden.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: `root`/`rem` are valid.
- `in_ready` output 1: block can accept an operand.
- `root` input ROOT_W: integer square root.
- `rem` input ROOT_W+1: remainder.
- `out_valid` output 1: `data`/`rem_err` are valid.
- `out_ready` input 1: consumer accepts the result.
- `data` output DATA_W: reconstructed radicand, `root*root + rem`, mod 2^DATA_W.
- `rem_err` output 1: the captured `rem > {root,1'b0}`.

## Operation
- **FSM states:** IDLE, CALC, DONE.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid&&in_ready`:
    - `mcand` ← `{ROOT_W'b0, root}`.
    - `mplier` ← `root`.
    - `acc` ← zero-extended `rem`.
    - `rem_err` ← (`rem > 2*root`), computed at ROOT_W+1 bits.
    - `cnt` ← 0.
    - Go to CALC.
- **CALC**, once per cycle:
  - If `mplier[0]`, then `acc` ← `acc + mcand` (DATA_W bits, carry-out dropped).
  - `mcand` ← `mcand<<1`; `mplier` ← `mplier>>1`; `cnt`++.
  - When `cnt==ROOT_W-1`, go to DONE after this iteration.
  - No early termination when `mplier` becomes 0; latency is fixed.
- **DONE**
  - `out_valid`=1; `data`=`acc`.
  - Outputs held stable until `out_ready`=1, then go to IDLE.
- **Arithmetic**
  - For canonical inputs, the maximum is (2^32-1)^2 + 2(2^32-1) = 2^64-1, so there is no overflow.
  - Non-canonical `rem` may wrap. The result is mod 2^DATA_W and is reported with `rem_err`=1.
- `in_ready` is asserted only in IDLE. No new operand is accepted while CALC or DONE is active. Input changes during CALC/DONE are ignored.
- **Reset (async, any state):**
  - State → IDLE.
  - `in_ready`=1, `out_valid`=0, `data`=0, `rem_err`=0.
  - `acc`/`mcand`/`mplier`/`cnt` cleared.
  - An in-flight operation is discarded with no output.

## Timing
- The accept edge E0 moves to CALC.
- Iterations run on edges E1..E32.
- `out_valid` is high from immediately after E32, i.e. 32 cycles after the accept edge.
- If `out_ready` is already high in DONE, the handshake completes at E33 and the block is back in IDLE. The next accept can happen at E34.
- Minimum throughput: one result per 34 cycles.
- `in_ready` is 0 from E0 until the edge that returns the FSM to IDLE.
- `rem_err` is valid together with `out_valid` and is constant from E0 onward.
- All outputs are registered; there are no combinational input→output paths except `in_ready`, which is decoded from state flops.

## Structure
- Shared package `sqrt_pkg` holds:
  - `DATA_W`/`ROOT_W` localparams, shared with `sqrt`.
  - The FSM state enum `{S_IDLE, S_CALC, S_DONE}`.
  - The counter width, `$clog2(ROOT_W)`.
- One natural sub-module: `sqrt_recon_dp`, holding the `acc`/`mcand`/`mplier` registers and the adder with load/step controls. The FSM and counter stay in the top level.

## Test plan
- root=4, rem=0 → `data`=16, `rem_err`=0; `out_valid` exactly 32 cycles after the accept edge.
- root=0x0FFFFFFF, rem=0x1FFFFFFE → `data`=0x00FF_FFFF_FFFF_FFFF, `rem_err`=0 (boundary: `rem` = 2·root).
- root=0xFFFFFFFF, rem=0x1_FFFFFFFE → `data`=0xFFFF_FFFF_FFFF_FFFF, no wrap; then root=256, rem=1 → 0x10001, and root=20, rem=0 → 400. Issue these back to back with `in_valid` held high, and check that accepts are spaced 34 cycles apart.
- root=3, rem=7 → `data`=16, `rem_err`=1; root=0, rem=0 → `data`=0, `rem_err`=0.
- Hold `out_ready`=0 for 10 cycles in DONE → `data`/`out_valid` stable and `in_ready`=0 throughout; raise `out_ready` → return to IDLE on the next edge.
- Assert `rst_n`=0 mid-CALC (cycle 15) → immediately `out_valid`=0, `data`=0, `in_ready`=1. After release, root=5, rem=2 → `data`=27, with no residue from the aborted operation.
